// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified instruction/data BRAM port between two masters:
// port 0 (CPU) and port 1 (loader / debug DMA). At most one access is
// accepted per cycle. The granted master's address, write data and byte
// strobes drive the BRAM. The BRAM's 1-cycle read data is returned to the
// requester together with a registered read-valid pulse.
//
// Handshake: a master raises mN_valid and holds mN_addr/mN_wdata/mN_wstrb
// stable until it sees mN_ready high. The transfer happens in the cycle where
// valid and ready are both high. mN_ready is combinational and is never high
// without mN_valid. A read (wstrb == 0) accepted in cycle T produces
// mN_rvalid in cycle T+1 with the data on mN_rdata. Writes produce no response.
//
// Parameters:
//   ADDR_W      word-address width
//   PORT0_PRIO  1: port 0 has fixed priority, with a starvation guard for port 1
//               0: round-robin between the two ports
//   STARVE_MAX  number of refused cycles port 1 tolerates before it is forced
//               a grant (1..255)
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   m0_* / m1_*                      master request channels and read returns
//   mem_addr/mem_wdata/mem_we/mem_re BRAM command outputs
//   mem_rdata                        BRAM read data (1-cycle latency)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int PORT0_PRIO = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

  logic [1:0] r_rd_pend;     // [N] = read accepted on port N last cycle
  logic       r_last_grant;  // port that received the most recent grant
  logic [7:0] r_starve_cnt;  // consecutive cycles port 1 waited while refused

  logic       w_gnt0;
  logic       w_gnt1;
  logic [3:0] w_sel_strb;
  logic       w_any_gnt;

  // Grant decision. Holding rst_n low blocks every grant, so the BRAM sees
  // no command while reset is asserted, whatever the masters request.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      case ({m1_valid, m0_valid})
        2'b01: w_gnt0 = 1'b1;
        2'b10: w_gnt1 = 1'b1;
        2'b11: begin
          if (PORT0_PRIO == 0) begin
            // Round-robin: the port that did not win last time goes now.
            if (r_last_grant) w_gnt0 = 1'b1;
            else              w_gnt1 = 1'b1;
          end else begin
            // Port 0 wins, except once port 1 has waited STARVE_MAX cycles.
            if (r_starve_cnt == LP_STARVE_MAX) w_gnt1 = 1'b1;
            else                               w_gnt0 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_sel_strb = w_gnt1 ? m1_wstrb : m0_wstrb;

  assign m0_ready  = w_gnt0;
  assign m1_ready  = w_gnt1;

  // Without a grant, the address and data buses follow port 0. They have no
  // effect because we/re are both low.
  assign mem_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign mem_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  assign mem_we    = w_any_gnt ? w_sel_strb : 4'b0000;
  assign mem_re    = w_any_gnt && (w_sel_strb == 4'b0000);

  // Both ports see the BRAM read bus. Only rvalid tells them whose data it is.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = r_rd_pend[0];
  assign m1_rvalid = r_rd_pend[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend    <= 2'b00;
      r_last_grant <= 1'b1;   // port 0 wins the first tie after reset
      r_starve_cnt <= 8'd0;
    end else begin
      r_rd_pend <= {w_gnt1 && (m1_wstrb == 4'b0000),
                    w_gnt0 && (m0_wstrb == 4'b0000)};
      if (w_any_gnt) begin
        r_last_grant <= w_gnt1;
      end
      if (m1_valid && !w_gnt1) begin
        if (r_starve_cnt != LP_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 8'd1;
        end
      end else begin
        r_starve_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives two arbiter instances with the same directed stimulus:
//   k = 0 : round-robin (PORT0_PRIO = 0)
//   k = 1 : fixed priority with STARVE_MAX = 4
// Each instance has its own BRAM model. A reference model, working per
// instance, applies the arbitration rules, tracks memory contents and tracks
// expected read returns. It is compared with the DUT on every negative
// clock edge. Hand-computed literal checks pin the main scenarios.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared master stimulus
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [31:0]   wd0, wd1;
  logic [3:0]    ws0, ws1;

  // per-instance outputs
  logic [1:0]    rdy0, rdy1, rv0, rv1, mre;
  logic [31:0]   rd0 [2];
  logic [31:0]   rd1 [2];
  logic [AW-1:0] maddr [2];
  logic [31:0]   mwd [2];
  logic [3:0]    mwe [2];
  logic [31:0]   mrd [2];

  mem_port_arbiter #(.ADDR_W(AW), .PORT0_PRIO(0), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(v0), .m0_addr(a0), .m0_wdata(wd0), .m0_wstrb(ws0),
    .m0_ready(rdy0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_valid(v1), .m1_addr(a1), .m1_wdata(wd1), .m1_wstrb(ws1),
    .m1_ready(rdy1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_we(mwe[0]), .mem_re(mre[0]),
    .mem_rdata(mrd[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .PORT0_PRIO(1), .STARVE_MAX(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(v0), .m0_addr(a0), .m0_wdata(wd0), .m0_wstrb(ws0),
    .m0_ready(rdy0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_valid(v1), .m1_addr(a1), .m1_wdata(wd1), .m1_wstrb(ws1),
    .m1_ready(rdy1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_we(mwe[1]), .mem_re(mre[1]),
    .mem_rdata(mrd[1])
  );

  // BRAM models (one per instance)
  logic [31:0] bram [2][DEPTH];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mre[k]) mrd[k] <= bram[k][maddr[k]];
      for (int b = 0; b < 4; b++) begin
        if (mwe[k][b]) bram[k][maddr[k]][8*b +: 8] <= mwd[k][8*b +: 8];
      end
    end
  end

  // scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic chk(input int k, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  // reference model state
  int          m_prio  [2] = '{0, 1};
  int          m_smax  [2] = '{4, 4};
  int          m_last  [2];
  int          m_starve[2];
  logic [1:0]  m_pend  [2];
  logic [31:0] m_pdata [2][2];
  logic [31:0] mm      [2][DEPTH];
  logic [31:0] hist    [2];   // ready of port 1 per cycle, newest in bit 0

  always @(negedge clk) begin
    int            g;
    logic [AW-1:0] sa;
    logic [31:0]   sd;
    logic [3:0]    ss;
    for (int k = 0; k < 2; k++) begin
      hist[k] = {hist[k][30:0], rdy1[k]};
      if (!rst_n) begin
        chk(k, "reset_ready", 32'({rdy1[k], rdy0[k]}), 32'd0);
        chk(k, "reset_we",    32'(mwe[k]), 32'd0);
        chk(k, "reset_re",    32'(mre[k]), 32'd0);
        chk(k, "reset_rvalid", 32'({rv1[k], rv0[k]}), 32'd0);
        m_last[k]   = 1;
        m_starve[k] = 0;
        m_pend[k]   = 2'b00;
      end else begin
        g = -1;
        if (v0 && !v1)      g = 0;
        else if (v1 && !v0) g = 1;
        else if (v0 && v1) begin
          if (m_prio[k] == 0) g = (m_last[k] == 0) ? 1 : 0;
          else                g = (m_starve[k] == m_smax[k]) ? 1 : 0;
        end
        chk(k, "ready", 32'({rdy1[k], rdy0[k]}),
            (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
        chk(k, "rvalid", 32'({rv1[k], rv0[k]}), 32'(m_pend[k]));
        if (m_pend[k][0]) chk(k, "rdata0", rd0[k], m_pdata[k][0]);
        if (m_pend[k][1]) chk(k, "rdata1", rd1[k], m_pdata[k][1]);
        if (g >= 0) begin
          sa = (g == 1) ? a1  : a0;
          sd = (g == 1) ? wd1 : wd0;
          ss = (g == 1) ? ws1 : ws0;
          chk(k, "mem_addr",  32'(maddr[k]), 32'(sa));
          chk(k, "mem_wdata", mwd[k], sd);
          chk(k, "mem_we",    32'(mwe[k]), 32'(ss));
          chk(k, "mem_re",    32'(mre[k]), (ss == 4'b0000) ? 32'd1 : 32'd0);
          m_last[k] = g;
        end else begin
          sa = a0; sd = wd0; ss = 4'b0000;
          chk(k, "idle_we", 32'(mwe[k]), 32'd0);
          chk(k, "idle_re", 32'(mre[k]), 32'd0);
        end
        // expected read returns for the next cycle
        m_pend[k] = 2'b00;
        if (g >= 0 && ss == 4'b0000) begin
          m_pend[k][g]     = 1'b1;
          m_pdata[k][g]    = mm[k][sa];
        end
        if (g >= 0) begin
          for (int b = 0; b < 4; b++)
            if (ss[b]) mm[k][sa][8*b +: 8] = sd[8*b +: 8];
        end
        if (v1 && g != 1) m_starve[k] = (m_starve[k] + 1 > m_smax[k]) ? m_smax[k] : m_starve[k] + 1;
        else              m_starve[k] = 0;
      end
    end
  end

  // driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0; v1 = 1'b0; ws0 = 4'h0; ws1 = 4'h0;
  endtask

  task automatic rd_req(input int port, input logic [AW-1:0] addr);
    if (port == 0) begin v0 = 1'b1; a0 = addr; ws0 = 4'h0; wd0 = 32'h0; end
    else           begin v1 = 1'b1; a1 = addr; ws1 = 4'h0; wd1 = 32'h0; end
  endtask

  task automatic wr_req(input int port, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
    if (port == 0) begin v0 = 1'b1; a0 = addr; ws0 = strb; wd0 = data; end
    else           begin v1 = 1'b1; a1 = addr; ws1 = strb; wd1 = data; end
  endtask

  int n_rv;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        bram[k][i] = 32'h1000_0000 + 32'(i);
        mm[k][i]   = 32'h1000_0000 + 32'(i);
      end
      bram[k][16] = 32'hDEADBEEF;
      mm[k][16]   = 32'hDEADBEEF;
      hist[k]     = 32'h0;
    end
    a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
    idle();

    // reset: requests are ignored while rst_n is low
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    step();
    for (int k = 0; k < 2; k++)
      chk(k, "lit_reset_no_ready", 32'({rdy1[k], rdy0[k], mwe[k], mre[k]}), 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();

    // port 0 read of preloaded 0x010
    rd_req(0, 14'h010);
    #1;
    for (int k = 0; k < 2; k++) chk(k, "lit_rd_ready", 32'({rdy1[k], rdy0[k]}), 32'd1);
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      chk(k, "lit_rd_rvalid", 32'({rv1[k], rv0[k]}), 32'd1);
      chk(k, "lit_rd_data", rd0[k], 32'hDEADBEEF);
    end
    step();

    // port 1 full write, port 0 read back, then partial write and read back
    wr_req(1, 14'h020, 32'hCAFEF00D, 4'hF);
    step(); idle();
    rd_req(0, 14'h020);
    step(); idle();
    for (int k = 0; k < 2; k++) chk(k, "lit_wr_full", rd0[k], 32'hCAFEF00D);
    wr_req(1, 14'h020, 32'h0000AAAA, 4'b0011);
    step(); idle();
    rd_req(0, 14'h020);
    step(); idle();
    for (int k = 0; k < 2; k++) chk(k, "lit_wr_part", rd0[k], 32'hCAFEAAAA);
    step();

    // contention pattern from a clean reset state
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd_req(0, 14'h040);
    rd_req(1, 14'h041);
    repeat (10) step();
    idle();
    chk(0, "lit_rr_pattern", 32'(hist[0][9:0]), 32'h155);  // 0101010101
    chk(1, "lit_fp_pattern", 32'(hist[1][9:0]), 32'h021);  // 0000100001
    step();

    // read accepted on port 1, reset asserted the very next cycle
    rd_req(1, 14'h041);
    step();
    rst_n = 1'b0;
    v0 = 1'b1;
    v1 = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk(k, "lit_rst_drop_rvalid", 32'(rv1[k]), 32'd0);
    step();
    rst_n = 1'b1;
    rd_req(0, 14'h050);
    rd_req(1, 14'h051);
    #1;
    for (int k = 0; k < 2; k++) chk(k, "lit_first_tie", 32'({rdy1[k], rdy0[k]}), 32'd1);
    step();
    idle();
    step();

    // back-to-back port 0 reads of 0x000..0x00F
    n_rv = 0;
    for (int i = 0; i < 16; i++) begin
      rd_req(0, AW'(i));
      step();
      if (rv0[1]) n_rv++;
      for (int k = 0; k < 2; k++) chk(k, "lit_burst_data", rd0[k], 32'h1000_0000 + 32'(i));
    end
    idle();
    chk(1, "lit_burst_count", 32'(n_rv), 32'd16);
    step();

    // mixed directed traffic, checked by the model only
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i % 3 != 0) rd_req(0, AW'(32'h60 + 32'(i)));
      if (i % 2 == 0) begin
        if (i % 4 == 0) wr_req(1, AW'(32'h60 + 32'(i) + 1), 32'h5000_0000 + 32'(i), 4'(i + 1));
        else            rd_req(1, AW'(32'h60 + 32'(i)));
      end
      step();
    end
    idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
